// File: rtl/sig_code_seq_if.sv
// Control/config and code-output bundle between a sequencer master and the
// sig_code_seq slave.
interface sig_code_seq_if #(
  parameter int WIDTH  = 3,
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 8
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                   start;
  logic                   abort;
  logic                   loop;
  logic [DEPTH*WIDTH-1:0] cfg_code;
  logic [HOLD_W-1:0]      cfg_hold;
  logic [WIDTH-1:0]       sig_out;
  logic                   sig_valid;
  logic                   busy;
  logic                   done;
  logic [IDX_W-1:0]       slot_idx;

  modport master (
    output start, abort, loop, cfg_code, cfg_hold,
    input  sig_out, sig_valid, busy, done, slot_idx
  );

  modport slave (
    input  start, abort, loop, cfg_code, cfg_hold,
    output sig_out, sig_valid, busy, done, slot_idx
  );
endinterface

// File: rtl/sig_code_seq.sv
// Code sequencer: latches a table of DEPTH codes plus a hold time on start and
// plays them out slot by slot, once or looping; drives IDLE_CODE otherwise.
module sig_code_seq #(
  parameter int             WIDTH     = 3,
  parameter int             DEPTH     = 4,
  parameter int             HOLD_W    = 8,
  parameter logic [WIDTH-1:0] IDLE_CODE = 3'b101
) (
  input  logic         clk,
  input  logic         rst_n,
  sig_code_seq_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]  code_q, code_d;
  logic [HOLD_W-1:0]            hold_q, hold_d;
  logic [HOLD_W-1:0]            cnt_q, cnt_d;
  logic                         loop_q, loop_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [WIDTH-1:0]             out_q, out_d;
  logic                         valid_q, valid_d;
  logic                         done_q, done_d;
  logic [IDX_W-1:0]             idx_nxt;

  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    idx_d   = idx_q;
    out_d   = out_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        out_d   = IDLE_CODE;
        valid_d = 1'b0;
        idx_d   = '0;
        if (bus.start && !bus.abort) begin
          code_d  = bus.cfg_code;
          hold_d  = bus.cfg_hold;
          loop_d  = bus.loop;
          cnt_d   = bus.cfg_hold;
          idx_d   = '0;
          out_d   = bus.cfg_code[WIDTH-1:0];
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          out_d   = IDLE_CODE;
          valid_d = 1'b0;
          idx_d   = '0;
        end else if (cnt_q == '0) begin
          if (idx_q != LAST) begin
            idx_d = idx_nxt;
            out_d = code_q[idx_nxt];
            cnt_d = hold_q;
          end else if (loop_q) begin
            idx_d = '0;
            out_d = code_q[0];
            cnt_d = hold_q;
          end else begin
            // Normal completion: the done pulse lands with the return to idle.
            state_d = IDLE;
            done_d  = 1'b1;
            out_d   = IDLE_CODE;
            valid_d = 1'b0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      idx_q   <= '0;
      out_q   <= IDLE_CODE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.sig_out   = out_q;
  assign bus.sig_valid = valid_q;
  assign bus.busy      = valid_q;
  assign bus.done      = done_q;
  assign bus.slot_idx  = idx_q;
endmodule

// File: doc/sig_code_seq.md
# sig_code_seq

Programmable 3-bit code sequencer that drives the local code signal consumed by the child stage's `sig_a` input. On a start request it latches a table of up to DEPTH codes and a per-slot hold time, then plays the codes out one slot at a time. It either stops after the last slot or loops until aborted. When idle it drives a fixed idle code, so the downstream stage always sees a defined value.

## Interface

- Clocking: one clock `clk`; reset `rst_n` is asynchronous and active-low.

Parameters:
- `WIDTH`, 3: code width; must match the downstream `sig_a` width.
- `DEPTH`, 4: number of code slots; legal range 2..16.
- `HOLD_W`, 8: width of the hold-count field.
- `IDLE_CODE`, 3'b101: value driven on `sig_out` whenever not running.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: start request; sampled only in IDLE.
- `abort` in 1: stop request; takes effect in any state.
- `loop` in 1: latched at start; 1 means wrap from the last slot to slot 0.
- `cfg_code` in DEPTH*WIDTH: code table; slot i is bits [i*WIDTH +: WIDTH]; latched at start.
- `cfg_hold` in HOLD_W: hold value H, latched at start; each slot lasts H+1 cycles.
- `sig_out` out WIDTH: current code to the downstream stage.
- `sig_valid` out 1: high while a table code is on `sig_out`.
- `busy` out 1: high in RUN.
- `done` out 1: single-cycle pulse on normal completion.
- `slot_idx` out clog2(DEPTH): index of the slot currently driven.

## Operation

- States are IDLE and RUN. All outputs are registered.
- Reset (asynchronous, any time, including mid-run):
  - state returns to IDLE;
  - `sig_out` = IDLE_CODE; `sig_valid`, `busy`, `done` = 0; `slot_idx` = 0;
  - latched table, hold and loop values are cleared to 0.
- IDLE to RUN requires `start`=1 and `abort`=0. On that edge:
  - latch `cfg_code`, `cfg_hold` and `loop`;
  - load the hold counter with H and set `slot_idx`=0;
  - drive `sig_out`=code[0], `sig_valid`=1, `busy`=1.
- In RUN, the hold counter decrements each cycle. When it is 0 at a clock edge:
  - if `slot_idx` < DEPTH-1: advance `slot_idx` by 1, drive the next code, reload the counter with H;
  - if `slot_idx` = DEPTH-1 and loop=1: wrap `slot_idx` to 0, drive code[0], reload with H; no `done`;
  - if `slot_idx` = DEPTH-1 and loop=0: go to IDLE with `done`=1 for exactly one cycle, `sig_out`=IDLE_CODE, `sig_valid`=0, `busy`=0, `slot_idx`=0.
- Abort:
  - `abort`=1 in RUN returns the block to IDLE on the next edge with idle outputs and `done`=0;
  - `abort`=1 in IDLE has no effect;
  - simultaneous `start` and `abort` in IDLE: abort wins, so the block does not start.
- `start` in RUN is ignored. Changes to `cfg_*` and `loop` during RUN are ignored until the next start.
- Back-to-back runs are allowed: `start` in the cycle where `done`=1 (state is IDLE) is accepted.

## Timing

- Start latency: `start` sampled high at edge k gives code[0] on `sig_out` from edge k onward, i.e. visible in cycle k+1.
- Slot duration is exactly H+1 cycles. H=0 gives one code per cycle; H=2^HOLD_W−1 gives a 2^HOLD_W-cycle slot with no overflow.
- A non-looping run lasts DEPTH·(H+1) cycles with `busy`=1. `done` is asserted in the following cycle, concurrent with the return to IDLE_CODE.
- Abort latency is 1 cycle. An abort in the final cycle of the last slot suppresses `done`.
- `sig_valid` and `busy` are identical in this revision; both are kept for the downstream interface.

## Test plan

- Reset values: assert `rst_n`=0 mid-run with H=5 → outputs immediately show `sig_out`=3'b101, `sig_valid`=0, `busy`=0, `done`=0, `slot_idx`=0. After release the block stays idle with no `start`.
- Single run, DEPTH=4, H=0, codes {1,2,3,4}, loop=0 → `sig_out` = 1,2,3,4 on four consecutive cycles, then 5 (IDLE_CODE) with `done`=1 for one cycle.
- Hold, H=2, same table → each code is held for 3 cycles, 12 busy cycles in total. `cfg_hold` changed to 0 mid-run has no effect.
- Loop and abort: loop=1, H=1 → sequence 1,1,2,2,3,3,4,4,1,1,… with no `done`. `abort` during slot 2 returns `sig_out`=5 and `busy`=0 on the next edge.
- Simultaneous events:
  - `start`+`abort` together in IDLE → no start;
  - `start` during RUN → ignored;
  - `start` in the `done` cycle → new run begins with code[0] in the next cycle.
- Maximum hold: H=255, DEPTH=2 → each slot lasts exactly 256 cycles and `done` appears at cycle 513.
